// File: rtl/uart_tx_fifo1_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo1_param
// Brief    : Parametrised UART transmitter with a one-word holding register so
//            frames can run back-to-back. Optional macro UART_TX_BREAK_EN adds
//            an i_break input for line-break / mark-after-break generation.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo1_param #(
    parameter int NB_BITS  = 8,
    parameter int SB_TICKS = 16,
    parameter int PARITY   = 0,
    parameter int NB_STOP  = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_rate,
    input  logic [NB_BITS-1:0] i_data,
    input  logic               i_data_ready,
`ifdef UART_TX_BREAK_EN
    input  logic               i_break,
`endif
    output logic               o_ready,
    output logic               o_tx,
    output logic               o_tx_done,
    output logic               o_busy
);

    localparam int TW = (SB_TICKS > 1) ? $clog2(SB_TICKS) : 1;
    localparam int BW = $clog2(NB_BITS + 1);
    localparam logic [TW-1:0] C_TICK_LAST = TW'(SB_TICKS - 1);
    localparam logic [BW-1:0] C_DATA_LAST = BW'(NB_BITS - 1);
    localparam logic [BW-1:0] C_STOP_LAST = BW'(NB_STOP - 1);
    localparam logic          C_PAR_EN    = (PARITY != 0);
    localparam logic          C_PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t               r_state;
    logic [TW-1:0]        r_tick;
    logic [BW-1:0]        r_bit_cnt;
    logic [NB_BITS-1:0]   r_shift;
    logic                 r_par;
    logic [NB_BITS-1:0]   r_hold_data;
    logic                 r_hold_valid;
    logic                 r_tx;
    logic                 r_done;
    logic                 r_busy;

    logic                 w_bit_end;
    logic                 w_accept;
    logic                 w_hold_block;
    logic                 w_stop_end;
    logic                 w_start;

`ifdef UART_TX_BREAK_EN
    localparam int MARK_TICKS = NB_STOP * SB_TICKS;
    localparam int MW = $clog2(MARK_TICKS);
    localparam logic [MW-1:0] C_MARK_LAST = MW'(MARK_TICKS - 1);

    logic          r_brk;
    logic          r_mark;
    logic [MW-1:0] r_mark_cnt;

    // Queued data is held back while the line is in break or mark-after-break.
    assign w_hold_block = i_break | r_brk | r_mark;
`else
    assign w_hold_block = 1'b0;
`endif

    assign w_bit_end  = i_rate && (r_tick == C_TICK_LAST);
    assign w_accept   = i_data_ready && !r_hold_valid;
    assign w_stop_end = (r_state == S_STOP) && w_bit_end && (r_bit_cnt == C_STOP_LAST);
    assign w_start    = r_hold_valid && !w_hold_block &&
                        ((r_state == S_IDLE) || w_stop_end);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_tick       <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_hold_data  <= '0;
            r_hold_valid <= 1'b0;
            r_tx         <= 1'b1;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
`ifdef UART_TX_BREAK_EN
            r_brk        <= 1'b0;
            r_mark       <= 1'b0;
            r_mark_cnt   <= '0;
`endif
        end else begin
            r_done <= 1'b0;

            if (w_accept) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= i_data;
            end

            if ((r_state != S_IDLE) && i_rate) begin
                r_tick <= w_bit_end ? '0 : r_tick + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
`ifdef UART_TX_BREAK_EN
                    if (i_break) begin
                        r_tx   <= 1'b0;
                        r_brk  <= 1'b1;
                        r_mark <= 1'b0;
                        r_busy <= 1'b1;
                    end else if (r_brk) begin
                        r_brk      <= 1'b0;
                        r_mark     <= 1'b1;
                        r_mark_cnt <= '0;
                        r_tx       <= 1'b1;
                        r_busy     <= 1'b1;
                    end else if (r_mark) begin
                        r_busy <= 1'b1;
                        if (i_rate) begin
                            if (r_mark_cnt == C_MARK_LAST) begin
                                r_mark <= 1'b0;
                            end else begin
                                r_mark_cnt <= r_mark_cnt + 1'b1;
                            end
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
`else
                    // Busy drops one clock after the done pulse.
                    r_busy <= 1'b0;
`endif
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state   <= S_DATA;
                        r_tx      <= r_shift[0];
                        r_bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == C_DATA_LAST) begin
                            r_bit_cnt <= '0;
                            if (C_PAR_EN) begin
                                r_state <= S_PAR;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                S_PAR: begin
                    if (w_bit_end) begin
                        r_state   <= S_STOP;
                        r_tx      <= 1'b1;
                        r_bit_cnt <= '0;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == C_STOP_LAST) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase

            // Launching a frame overrides the STOP->IDLE move so frames abut.
            if (w_start) begin
                r_state      <= S_START;
                r_shift      <= r_hold_data;
                r_par        <= (^r_hold_data) ^ C_PAR_ODD;
                r_hold_valid <= 1'b0;
                r_tick       <= '0;
                r_bit_cnt    <= '0;
                r_tx         <= 1'b0;
                r_busy       <= 1'b1;
            end
        end
    end

    assign o_ready   = !r_hold_valid;
    assign o_tx      = r_tx;
    assign o_tx_done = r_done;
    assign o_busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo1_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo1_param
// Brief    : Scoreboard bench for four transmitter configurations sharing one
//            clock, rate tick and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo1_param;

    localparam int BP = 64;  // clocks per bit: 16 ticks x 4 clocks

    typedef struct {
        int          id;
        int          len;
        logic [15:0] bits;
        bit          b2b;
        bit          idle_after;
        bit          abort;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] div = 2'd0;
    logic       rate;
    logic [8:0] data = '0;
    logic [3:0] dr_v = '0;
    logic [3:0] tx_v, done_v, busy_v, rdy_v;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   mon_busy = 1'b0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) begin
        div <= div + 2'd1;
        cyc <= cyc + 1;
    end
    assign rate = (div == 2'd3);

    uart_tx_fifo1_param dut0 (
        .i_clk(clk), .i_rst(rst_n), .i_rate(rate), .i_data(data[7:0]),
        .i_data_ready(dr_v[0]), .o_ready(rdy_v[0]), .o_tx(tx_v[0]),
        .o_tx_done(done_v[0]), .o_busy(busy_v[0]));

    uart_tx_fifo1_param #(.PARITY(1)) dut1 (
        .i_clk(clk), .i_rst(rst_n), .i_rate(rate), .i_data(data[7:0]),
        .i_data_ready(dr_v[1]), .o_ready(rdy_v[1]), .o_tx(tx_v[1]),
        .o_tx_done(done_v[1]), .o_busy(busy_v[1]));

    uart_tx_fifo1_param #(.PARITY(2)) dut2 (
        .i_clk(clk), .i_rst(rst_n), .i_rate(rate), .i_data(data[7:0]),
        .i_data_ready(dr_v[2]), .o_ready(rdy_v[2]), .o_tx(tx_v[2]),
        .o_tx_done(done_v[2]), .o_busy(busy_v[2]));

    uart_tx_fifo1_param #(.NB_BITS(7), .NB_STOP(2)) dut3 (
        .i_clk(clk), .i_rst(rst_n), .i_rate(rate), .i_data(data[6:0]),
        .i_data_ready(dr_v[3]), .o_ready(rdy_v[3]), .o_tx(tx_v[3]),
        .o_tx_done(done_v[3]), .o_busy(busy_v[3]));

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push(input int id, input int len, input logic [15:0] bits,
                        input bit b2b, input bit idle_after, input bit abort);
        exp_t e;
        e.id = id; e.len = len; e.bits = bits;
        e.b2b = b2b; e.idle_after = idle_after; e.abort = abort;
        exp_q.push_back(e);
    endtask

    // Accept edge is placed just before a rate edge so that the first tick
    // after START entry comes a full 4 clocks later.
    task automatic send(input int id, input logic [8:0] d);
        do @(negedge clk); while (div != 2'd2);
        data = d;
        dr_v[id] = 1'b1;
        @(negedge clk);
        dr_v[id] = 1'b0;
    endtask

    task automatic pulse_write(input int id, input logic [8:0] d);
        data = d;
        dr_v[id] = 1'b1;
        @(negedge clk);
        dr_v[id] = 1'b0;
    endtask

    task automatic wait_idle();
        int timed_out;
        timed_out = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mon_busy) begin
                timed_out = 0;
                break;
            end
        end
        check("drain_timeout", timed_out, 0);
        repeat (20) @(negedge clk);
    endtask

    // Monitor: detects a start bit on any instance, pops the expected frame
    // and checks bit values, done timing, back-to-back launch and busy fall.
    initial begin : monitor
        bit          resume;
        int          id, start_cyc, last_done_cyc, dcnt, done_at, aborted;
        logic [15:0] cap;
        exp_t        e;
        resume = 1'b0;
        last_done_cyc = -1;
        forever begin
            if (!resume) @(negedge clk);
            resume = 1'b0;
            if (!rst_n) continue;
            id = -1;
            for (int i = 3; i >= 0; i--) if (tx_v[i] == 1'b0) id = i;
            if (id < 0) continue;
            mon_busy = 1'b1;
            start_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame on dut%0d at cycle %0d, required none", id, cyc);
                repeat (800) @(negedge clk);
                mon_busy = 1'b0;
                continue;
            end
            e = exp_q.pop_front();
            check("frame_dut_id", id, e.id);
            if (e.b2b) check("b2b_start_cycle", start_cyc, last_done_cyc);
            cap = '0; dcnt = 0; done_at = -1; aborted = 0;
            for (int n = 1; n <= e.len * BP; n++) begin
                @(negedge clk);
                if (!rst_n) begin
                    aborted = 1;
                    break;
                end
                if ((n % BP) == BP / 2) cap = {cap[14:0], tx_v[e.id]};
                if (done_v[e.id]) begin
                    dcnt++;
                    if (done_at < 0) done_at = n;
                end
            end
            check("frame_aborted", aborted, int'(e.abort));
            if (aborted) begin
                check("abort_no_done", dcnt, 0);
            end else begin
                check("frame_bits", int'(cap), int'(e.bits));
                check("done_count", dcnt, 1);
                check("done_offset", done_at, e.len * BP);
                last_done_cyc = cyc;
                if (tx_v[e.id] == 1'b0) begin
                    resume = 1'b1;
                end else if (e.idle_after) begin
                    check("busy_at_done", int'(busy_v[e.id]), 1);
                    @(negedge clk);
                    check("busy_after_done", int'(busy_v[e.id]), 0);
                end
            end
            mon_busy = 1'b0;
        end
    end

    initial begin : stimulus
        repeat (2) @(negedge clk);
        check("reset_tx", int'(tx_v), 4'hF);
        check("reset_done", int'(done_v), 4'h0);
        check("reset_busy", int'(busy_v), 4'h0);
        check("reset_ready", int'(rdy_v), 4'hF);
        #1 rst_n = 1'b1;

        // 8N1, 8'h53
        push(0, 10, 16'(10'b0_11001010_1), 1'b0, 1'b1, 1'b0);
        send(0, 9'h053);
        wait_idle();

        // Even and odd parity, 8'h53 has four ones
        push(1, 11, 16'(11'b0_11001010_0_1), 1'b0, 1'b1, 1'b0);
        send(1, 9'h053);
        wait_idle();
        push(2, 11, 16'(11'b0_11001010_1_1), 1'b0, 1'b1, 1'b0);
        send(2, 9'h053);
        wait_idle();

        // 7 data bits, 2 stop bits, 7'h41
        push(3, 10, 16'(10'b0_1000001_11), 1'b0, 1'b1, 1'b0);
        send(3, 9'h041);
        wait_idle();

        // Back-to-back: 8'hA5 then 8'h3C queued mid-frame, third write dropped
        push(0, 10, 16'(10'b0_10100101_1), 1'b0, 1'b0, 1'b0);
        send(0, 9'h0A5);
        repeat (200) @(negedge clk);
        check("ready_mid_frame", int'(rdy_v[0]), 1);
        push(0, 10, 16'(10'b0_00111100_1), 1'b1, 1'b1, 1'b0);
        pulse_write(0, 9'h03C);
        check("ready_when_full", int'(rdy_v[0]), 0);
        pulse_write(0, 9'h0FF);
        check("busy_mid_frame", int'(busy_v[0]), 1);
        wait_idle();

        // Reset during data bit 3, then a clean 8'h0F frame
        push(0, 10, 16'h0000, 1'b0, 1'b0, 1'b1);
        send(0, 9'h096);
        repeat (300) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx", int'(tx_v[0]), 1);
        check("async_rst_busy", int'(busy_v[0]), 0);
        check("async_rst_ready", int'(rdy_v[0]), 1);
        repeat (3) @(negedge clk);
        check("rst_no_done", int'(done_v[0]), 0);
        #1 rst_n = 1'b1;
        push(0, 10, 16'(10'b0_11110000_1), 1'b0, 1'b1, 1'b0);
        send(0, 9'h00F);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
